gb_lcd_scaler: RTL and testbench
================================

// Module: gb_lcd_scaler
// PURPOSE
//  Pixel stage directly downstream of the 640x480 VGA timing generator.
//  - Consumes its x/y counters and sync/blank flags.
//  - Fetches 2-bit Game Boy shades from a 160x144 framebuffer RAM (synchronous read, 1-cycle latency).
//  - Upscales by SCALE, centres the image with a border, and drives palette-mapped RGB to the DAC.
//  - Sync and blank outputs are delayed so they stay aligned with the pixel data.
// PARAMETERS
//  GB_W        160         source width in pixels
//  GB_H        144         source height in pixels
//  SCALE       3           integer upscale factor; window is 480x432
//  H_OFFSET    80          first window column in VGA x
//  V_OFFSET    24          first window line in VGA y
//  BORDER_RGB  24'h202020  colour outside the window while not blanked
// PORTS
//  clock_25_125mhz  in   1   pixel clock, same clock as the timing generator
//  reset            in   1   asynchronous, active-high
//  x                in   13  horizontal counter from timing generator
//  y                in   13  vertical counter from timing generator
//  hs_in            in   1   horizontal sync, negative
//  vs_in            in   1   vertical sync, negative
//  hblank_in        in   1   0 during hblank
//  vblank_in        in   1   0 during vblank
//  fb_addr          out  15  framebuffer read address = row*GB_W + col
//  fb_rd            out  1   read strobe, high only inside the window
//  fb_data          in   2   shade; valid 1 cycle after fb_addr/fb_rd
//  hs               out  1   hs_in delayed 3 cycles
//  vs               out  1   vs_in delayed 3 cycles
//  blank_n          out  1   (hblank_in & vblank_in) delayed 3 cycles
//  r, g, b          out  8   each; pixel colour
// BEHAVIOUR
//  Reset values:
//   - hs=1, vs=1, blank_n=0, r=g=b=0, fb_addr=0, fb_rd=0.
//   - All counters 0; all pipeline registers filled with the inactive values above.
//  Pipeline: fixed 3-cycle latency from x/y to RGB.
//   - S1: register fb_addr and fb_rd, plus in_win / border / visible flags.
//   - S2: RAM returns fb_data; flags advance one stage.
//   - S3: palette lookup; r/g/b, hs, vs and blank_n registered together.
//  Window: in_win = (H_OFFSET <= x < H_OFFSET+GB_W*SCALE) && (V_OFFSET <= y < V_OFFSET+GB_H*SCALE).
//  Addressing uses no multiplier:
//   - col (0..GB_W-1) and sub_x (0..SCALE-1) clear at x==H_OFFSET-1.
//   - While in_win, sub_x increments each cycle; on wrap, col increments.
//   - row_base (step GB_W) and sub_y clear while y<V_OFFSET.
//   - At x==H_OFFSET+GB_W*SCALE-1 on an in-window line, sub_y increments; on wrap, row_base += GB_W.
//   - fb_addr = row_base + col, computed in 15 bits. Max 23039, so no overflow.
//  Palette, fb_data -> RGB:
//   - 0 -> E0F8D0
//   - 1 -> 88C070
//   - 2 -> 346856
//   - 3 -> 081820
//  Output colour by case:
//   - Visible and outside the window: BORDER_RGB.
//   - Blanked (blank_n=0): RGB = 0. This overrides everything else.
//  Boundaries:
//   - At x==H_OFFSET+GB_W*SCALE, fb_rd falls and fb_addr holds its last value.
//   - Last line of the window: row_base reaches 143*160=22880; no further increment.
//   - vblank: counters hold until y wraps to 0, then re-clear.
//  Reset mid-frame:
//   - Outputs are forced inactive immediately.
//   - The remainder of the current frame may show shifted rows.
//   - Output must be correct from the first frame starting after reset release.
// CONFIGURATION
//  GB_SCALER_GRID_EN
//   - Defined: LCD grid effect. When sub_x==SCALE-1 or sub_y==SCALE-1, each RGB channel is halved
//     (logical shift right by 1). The border is never dimmed.
//   - Undefined: every sub-pixel of a source pixel has the identical colour.
//   - Latency is 3 cycles in both builds.
// TESTING
//  1. Hold reset across a clock edge
//     -> hs=vs=1, blank_n=0, rgb=0, fb_rd=0; release gives first valid RGB 3 cycles after in_win.
//  2. Framebuffer all shade 1, x=80, y=24
//     -> fb_addr=0 at S1; rgb=88C070 three cycles later; x=79 gives 202020.
//  3. Source pixel (col 5, row 2) = shade 3, others 0
//     -> VGA x 95..97, y 30..32 read 0x0145 (325) and show 081820; all other window pixels show E0F8D0.
//  4. Last source pixel: x=559, y=455
//     -> fb_addr=23039; x=560 -> fb_rd=0 and border colour 3 cycles later.
//  5. Blanking: x=640..799 or y=480..524
//     -> rgb=0 and blank_n=0; hs low exactly for x=657..751 input, shifted 3 cycles.
//  6. GB_SCALER_GRID_EN defined, shade 0 everywhere
//     -> x=82 (sub_x=2) gives 707C68; x=80 gives E0F8D0.

Source files
------------

// File: rtl/gb_lcd_scaler.sv
// Game Boy 160x144 framebuffer to 640x480 VGA pixel stage: integer upscale, centring border, palette.
// Optional LCD grid dimming on the last sub-pixel row/column is enabled by defining GB_SCALER_GRID_EN.
module gb_lcd_scaler #(
    parameter int          GB_W       = 160,
    parameter int          GB_H       = 144,
    parameter int          SCALE      = 3,
    parameter int          H_OFFSET   = 80,
    parameter int          V_OFFSET   = 24,
    parameter logic [23:0] BORDER_RGB = 24'h202020
) (
    input  logic        clock_25_125mhz,
    input  logic        reset,
    input  logic [12:0] x,
    input  logic [12:0] y,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    output logic [14:0] fb_addr,
    output logic        fb_rd,
    input  logic [1:0]  fb_data,
    output logic        hs,
    output logic        vs,
    output logic        blank_n,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam int CW = $clog2(GB_W);
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [12:0]   X_PRE    = 13'(H_OFFSET - 1);
    localparam logic [12:0]   X_FIRST  = 13'(H_OFFSET);
    localparam logic [12:0]   X_LAST   = 13'(H_OFFSET + GB_W * SCALE - 1);
    localparam logic [12:0]   X_END    = 13'(H_OFFSET + GB_W * SCALE);
    localparam logic [12:0]   Y_FIRST  = 13'(V_OFFSET);
    localparam logic [12:0]   Y_END    = 13'(V_OFFSET + GB_H * SCALE);
    localparam logic [CW-1:0] COL_LAST = CW'(GB_W - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
    localparam logic [14:0]   ROW_STEP = 15'(GB_W);
    localparam logic [14:0]   ROW_LAST = 15'((GB_H - 1) * GB_W);

    function automatic logic [23:0] palette(input logic [1:0] shade);
        case (shade)
            2'd0:    palette = 24'hE0F8D0;
            2'd1:    palette = 24'h88C070;
            2'd2:    palette = 24'h346856;
            default: palette = 24'h081820;
        endcase
    endfunction

    logic          line_in_win;
    logic          in_win;
    logic          visible;
    logic [CW-1:0] col;
    logic [SW-1:0] sub_x;
    logic [14:0]   row_base;
    logic [SW-1:0] sub_y;

    always_comb begin
        line_in_win = (y >= Y_FIRST) && (y < Y_END);
        in_win      = line_in_win && (x >= X_FIRST) && (x < X_END);
        visible     = hblank_in & vblank_in;
    end

    // Counters track the source pixel under the current x/y, so addressing needs only adds.
    // NOTE: every clocked block uses <= so all registers sample pre-edge values together.
    always_ff @(posedge clock_25_125mhz or posedge reset) begin
        if (reset) begin
            col      <= '0;
            sub_x    <= '0;
            row_base <= '0;
            sub_y    <= '0;
        end else begin
            if (x == X_PRE) begin
                col   <= '0;
                sub_x <= '0;
            end else if (in_win) begin
                if (sub_x == SUB_LAST) begin
                    sub_x <= '0;
                    if (col != COL_LAST) col <= col + 1'b1;
                end else begin
                    sub_x <= sub_x + 1'b1;
                end
            end

            if (y < Y_FIRST) begin
                row_base <= '0;
                sub_y    <= '0;
            end else if (line_in_win && (x == X_LAST)) begin
                if (sub_y == SUB_LAST) begin
                    sub_y <= '0;
                    if (row_base != ROW_LAST) row_base <= row_base + ROW_STEP;
                end else begin
                    sub_y <= sub_y + 1'b1;
                end
            end
        end
    end

    logic win1, vis1, hs1, vs1;
    logic win2, vis2, hs2, vs2;
`ifdef GB_SCALER_GRID_EN
    logic grid1, grid2;
`endif

    // S1 issues the read; S2 waits for the RAM; fb_addr holds outside the window.
    always_ff @(posedge clock_25_125mhz or posedge reset) begin
        if (reset) begin
            fb_addr <= '0;
            fb_rd   <= 1'b0;
            win1    <= 1'b0;
            vis1    <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            win2    <= 1'b0;
            vis2    <= 1'b0;
            hs2     <= 1'b1;
            vs2     <= 1'b1;
`ifdef GB_SCALER_GRID_EN
            grid1   <= 1'b0;
            grid2   <= 1'b0;
`endif
        end else begin
            fb_rd <= in_win;
            if (in_win) fb_addr <= row_base + 15'(col);
            win1  <= in_win;
            vis1  <= visible;
            hs1   <= hs_in;
            vs1   <= vs_in;
            win2  <= win1;
            vis2  <= vis1;
            hs2   <= hs1;
            vs2   <= vs1;
`ifdef GB_SCALER_GRID_EN
            grid1 <= (sub_x == SUB_LAST) || (sub_y == SUB_LAST);
            grid2 <= grid1;
`endif
        end
    end

    logic [23:0] pix;
    logic [23:0] rgb_next;

    // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
    always_comb begin
        pix = palette(fb_data);
`ifdef GB_SCALER_GRID_EN
        if (grid2) pix = {1'b0, pix[23:17], 1'b0, pix[15:9], 1'b0, pix[7:1]};
`endif
        if (!vis2)      rgb_next = 24'h000000;
        else if (!win2) rgb_next = BORDER_RGB;
        else            rgb_next = pix;
    end

    always_ff @(posedge clock_25_125mhz or posedge reset) begin
        if (reset) begin
            r       <= '0;
            g       <= '0;
            b       <= '0;
            hs      <= 1'b1;
            vs      <= 1'b1;
            blank_n <= 1'b0;
        end else begin
            r       <= rgb_next[23:16];
            g       <= rgb_next[15:8];
            b       <= rgb_next[7:0];
            hs      <= hs2;
            vs      <= vs2;
            blank_n <= vis2;
        end
    end

endmodule

// File: tb/tb_gb_lcd_scaler.sv
// Directed bench for gb_lcd_scaler: scans selected VGA lines, checks table points at their pipeline delay.
// Expected colours follow GB_SCALER_GRID_EN when the bench is built with that macro.
module tb_gb_lcd_scaler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] x = '0;
    logic [12:0] y = '0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        hblank_in = 1'b0;
    logic        vblank_in = 1'b0;
    logic [14:0] fb_addr;
    logic        fb_rd;
    logic [1:0]  fb_data = '0;
    logic        hs, vs, blank_n;
    logic [7:0]  r, g, b;

    gb_lcd_scaler dut (
        .clock_25_125mhz(clk),
        .reset          (reset),
        .x              (x),
        .y              (y),
        .hs_in          (hs_in),
        .vs_in          (vs_in),
        .hblank_in      (hblank_in),
        .vblank_in      (vblank_in),
        .fb_addr        (fb_addr),
        .fb_rd          (fb_rd),
        .fb_data        (fb_data),
        .hs             (hs),
        .vs             (vs),
        .blank_n        (blank_n),
        .r              (r),
        .g              (g),
        .b              (b)
    );

    always #20 clk = ~clk;

    // Framebuffer model: synchronous read, one cycle latency.
    logic [1:0] mem [0:23039];
    always @(posedge clk) if (fb_rd) fb_data <= mem[fb_addr];

    localparam logic [23:0] BRD = 24'h202020;
    localparam logic [23:0] C0  = 24'hE0F8D0;
    localparam logic [23:0] C1  = 24'h88C070;
    localparam logic [23:0] C2  = 24'h346856;
    localparam logic [23:0] C3  = 24'h081820;
`ifdef GB_SCALER_GRID_EN
    localparam logic [23:0] C0G = 24'h707C68;
    localparam logic [23:0] C1G = 24'h446038;
    localparam logic [23:0] C2G = 24'h1A342B;
    localparam logic [23:0] C3G = 24'h040C10;
`else
    localparam logic [23:0] C0G = C0;
    localparam logic [23:0] C1G = C1;
    localparam logic [23:0] C2G = C2;
    localparam logic [23:0] C3G = C3;
`endif

    typedef struct {
        int          ph;
        int          xv;
        int          yv;
        logic [23:0] rgb;
        logic        blank;
        logic        hsv;
        logic        vsv;
        logic        rd;
        logic        chk_addr;
        logic [14:0] addr;
        bit          hit;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   cur_ph = -1;
    int   tag[3] = '{-1, -1, -1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int ph, input int xv, input int yv, input logic [23:0] rgb,
                       input logic blank, input logic hsv, input logic vsv, input logic rd,
                       input logic chk_addr, input int addr);
        vec_t v;
        v.ph = ph; v.xv = xv; v.yv = yv; v.rgb = rgb; v.blank = blank; v.hsv = hsv;
        v.vsv = vsv; v.rd = rd; v.chk_addr = chk_addr; v.addr = 15'(addr); v.hit = 1'b0;
        vecs.push_back(v);
    endtask

    function automatic int lookup(input int ph, input int xv, input int yv);
        for (int i = 0; i < vecs.size(); i++)
            if (vecs[i].ph == ph && vecs[i].xv == xv && vecs[i].yv == yv) return i;
        return -1;
    endfunction

    // One pixel clock: check outputs due now, then drive the next x/y like the timing generator.
    task automatic step(input int xv, input int yv);
        int i;
        @(negedge clk);
        if (tag[2] >= 0) begin
            i = tag[2];
            check($sformatf("v%0d(%0d,%0d) rgb", i, vecs[i].xv, vecs[i].yv), {8'h00, r, g, b}, {8'h00, vecs[i].rgb});
            check($sformatf("v%0d blank_n", i), 32'(blank_n), 32'(vecs[i].blank));
            check($sformatf("v%0d hs", i), 32'(hs), 32'(vecs[i].hsv));
            check($sformatf("v%0d vs", i), 32'(vs), 32'(vecs[i].vsv));
            vecs[i].hit = 1'b1;
        end
        if (tag[0] >= 0) begin
            i = tag[0];
            check($sformatf("v%0d(%0d,%0d) fb_rd", i, vecs[i].xv, vecs[i].yv), 32'(fb_rd), 32'(vecs[i].rd));
            if (vecs[i].chk_addr)
                check($sformatf("v%0d fb_addr", i), 32'(fb_addr), 32'(vecs[i].addr));
        end
        tag[2] = tag[1];
        tag[1] = tag[0];
        tag[0] = lookup(cur_ph, xv, yv);
        x         = 13'(xv);
        y         = 13'(yv);
        hs_in     = !(xv >= 657 && xv <= 751);
        vs_in     = !(yv >= 490 && yv <= 491);
        hblank_in = (xv < 640);
        vblank_in = (yv < 480);
    endtask

    task automatic scan_line(input int yv, input int x0, input int x1);
        for (int xx = x0; xx <= x1; xx++) step(xx, yv);
    endtask

    task automatic flush();
        cur_ph = -1;
        repeat (3) step(0, 0);
    endtask

    task automatic fill(input logic [1:0] shade);
        for (int i = 0; i < 23040; i++) mem[i] = shade;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Phase 1: every shade 1.
        add(1,  79, 24, BRD, 1, 1, 1, 0, 0, 0);
        add(1,  80, 24, C1,  1, 1, 1, 1, 1, 0);
        add(1,  82, 24, C1G, 1, 1, 1, 1, 1, 0);
        add(1,  83, 24, C1,  1, 1, 1, 1, 1, 1);
        add(1, 559, 24, C1G, 1, 1, 1, 1, 1, 159);
        add(1, 560, 24, BRD, 1, 1, 1, 0, 1, 159);
        add(1,  80, 23, BRD, 1, 1, 1, 0, 0, 0);
        add(1,  80, 25, C1,  1, 1, 1, 1, 1, 0);
        // Phase 2: source (col 5, row 2) = shade 3, rest shade 0.
        add(2,  95, 30, C3,  1, 1, 1, 1, 1, 325);
        add(2,  97, 32, C3G, 1, 1, 1, 1, 1, 325);
        add(2,  92, 30, C0,  1, 1, 1, 1, 1, 324);
        add(2,  98, 31, C0,  1, 1, 1, 1, 1, 326);
        add(2,  95, 33, C0,  1, 1, 1, 1, 1, 485);
        add(2,  95, 29, C0G, 1, 1, 1, 1, 1, 165);
        add(2,  80, 24, C0,  1, 1, 1, 1, 1, 0);
        add(2,  82, 24, C0G, 1, 1, 1, 1, 1, 0);
        // Phase 3: last source pixel = shade 2, rest shade 0.
        add(3,  80, 455, C0G, 1, 1, 1, 1, 1, 22880);
        add(3, 556, 455, C0G, 1, 1, 1, 1, 1, 23038);
        add(3, 557, 455, C2G, 1, 1, 1, 1, 1, 23039);
        add(3, 559, 455, C2G, 1, 1, 1, 1, 1, 23039);
        add(3, 560, 455, BRD, 1, 1, 1, 0, 1, 23039);
        add(3,  80, 456, BRD, 1, 1, 1, 0, 0, 0);
        // Phase 4: blanking and sync.
        add(4, 639, 470, BRD, 1, 1, 1, 0, 0, 0);
        add(4, 640, 470, 0,   0, 1, 1, 0, 0, 0);
        add(4, 656, 470, 0,   0, 1, 1, 0, 0, 0);
        add(4, 657, 470, 0,   0, 0, 1, 0, 0, 0);
        add(4, 751, 470, 0,   0, 0, 1, 0, 0, 0);
        add(4, 752, 470, 0,   0, 1, 1, 0, 0, 0);
        add(4, 799, 470, 0,   0, 1, 1, 0, 0, 0);
        add(4, 100, 479, BRD, 1, 1, 1, 0, 0, 0);
        add(4, 100, 480, 0,   0, 1, 1, 0, 0, 0);
        add(4, 100, 489, 0,   0, 1, 1, 0, 0, 0);
        add(4, 100, 490, 0,   0, 1, 0, 0, 0, 0);
        add(4, 100, 524, 0,   0, 1, 1, 0, 0, 0);

        // Reset held across edges.
        fill(2'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset hs", 32'(hs), 1);
        check("reset vs", 32'(vs), 1);
        check("reset blank_n", 32'(blank_n), 0);
        check("reset rgb", {8'h00, r, g, b}, 0);
        check("reset fb_rd", 32'(fb_rd), 0);
        check("reset fb_addr", 32'(fb_addr), 0);
        reset = 1'b0;

        cur_ph = 1;
        for (int yy = 23; yy <= 25; yy++) scan_line(yy, 70, 565);
        flush();

        // Reset mid-frame while a window pixel is on the outputs.
        repeat (5) step(100, 25);
        check("pre-reset rgb", {8'h00, r, g, b}, {8'h00, C1});
        #5 reset = 1'b1;
        #1;
        check("async reset rgb", {8'h00, r, g, b}, 0);
        check("async reset blank_n", 32'(blank_n), 0);
        check("async reset hs", 32'(hs), 1);
        check("async reset fb_rd", 32'(fb_rd), 0);
        check("async reset fb_addr", 32'(fb_addr), 0);
        @(negedge clk);
        reset = 1'b0;
        tag = '{-1, -1, -1};

        fill(2'd0);
        mem[325] = 2'd3;
        cur_ph = 2;
        for (int yy = 22; yy <= 34; yy++) scan_line(yy, 70, 565);
        flush();

        fill(2'd0);
        mem[23039] = 2'd2;
        cur_ph = 3;
        step(559, 23);
        for (int yy = 24; yy <= 454; yy++) step(559, yy);
        scan_line(455, 75, 565);
        scan_line(456, 75, 85);
        flush();

        cur_ph = 4;
        scan_line(470, 630, 799);
        foreach (vecs[i]) if (vecs[i].ph == 4 && vecs[i].yv != 470) scan_line(vecs[i].yv, 95, 105);
        flush();

        foreach (vecs[i]) check($sformatf("v%0d reached", i), 32'(vecs[i].hit), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
